// File: rtl/spmv_pkg.sv
// Shared constants and packer state encoding for the SpMV result path.
package spmv_pkg;

    localparam int unsigned ROW_W    = 5;
    localparam int unsigned DATA_W   = 21;
    localparam int unsigned NUM_ROWS = 32;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } pack_state_e;

endpackage

// File: rtl/spmv_row_buf.sv
// Per-row accumulate register file with written bits, one masked read port and clear-all.
module spmv_row_buf
    import spmv_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 32,
    parameter int unsigned DATA_W   = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ROW_W-1:0]    wr_row,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ROW_W-1:0]    rd_row,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                clear,
    output logic [NUM_ROWS-1:0] written
);

    logic [DATA_W-1:0] mem [NUM_ROWS];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en && (32'(wr_row) < NUM_ROWS);
    assign rd_ok = (32'(rd_row) < NUM_ROWS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
        end else if (clear) begin
            written <= '0;
        end else if (wr_ok) begin
            written[wr_row] <= 1'b1;
        end
    end

    // Data needs no reset: an unwritten row is masked to zero on read.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_row] <= written[wr_row] ? mem[wr_row] + wr_data : wr_data;
        end
    end

    assign rd_data = (rd_ok && written[rd_row]) ? mem[rd_row] : '0;

endmodule

// File: rtl/spmv_result_packer.sv
// Collects sparse SpMV row results and drains them as an ordered dense stream.
// Optional macro SPMV_PACK_SKIP_ZERO_EN: drain only rows that were written.
module spmv_result_packer
    import spmv_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 32,
    parameter int unsigned DATA_W   = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ROW_W-1:0]  in_row,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_finish,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    pack_state_e         state_q, state_d;
    logic [ROW_W-1:0]    idx_q, idx_d;
    logic [ROW_W-1:0]    first_idx, next_idx;
    logic                is_last;
    logic                wr_en, clear_all, xfer, drop;
    logic [NUM_ROWS-1:0] written;
    logic [DATA_W-1:0]   rd_data;

    spmv_row_buf #(
        .NUM_ROWS (NUM_ROWS),
        .DATA_W   (DATA_W)
    ) u_row_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_row  (in_row),
        .wr_data (in_data),
        .rd_row  (idx_q),
        .rd_data (rd_data),
        .clear   (clear_all),
        .written (written)
    );

`ifdef SPMV_PACK_SKIP_ZERO_EN
    logic [NUM_ROWS-1:0] pending, above;

    function automatic logic [ROW_W-1:0] lowest_set(input logic [NUM_ROWS-1:0] v);
        logic [ROW_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (v[i] && !found) begin
                r     = ROW_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // The first row must include a beat written in the same cycle as in_finish.
    always_comb begin
        pending = written;
        if (in_valid && (32'(in_row) < NUM_ROWS)) begin
            pending[in_row] = 1'b1;
        end
        above = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            above[i] = written[i] && (i > 32'(idx_q));
        end
        first_idx = lowest_set(pending);
        next_idx  = lowest_set(above);
        is_last   = ~|above;
    end
`else
    assign first_idx = '0;
    assign next_idx  = idx_q + 1'b1;
    assign is_last   = (idx_q == ROW_W'(NUM_ROWS - 1));
`endif

    assign busy      = (state_q == DRAIN);
    assign out_valid = busy;
    assign out_idx   = idx_q;
    assign out_data  = busy ? rd_data : '0;
    assign out_last  = busy && is_last;
    assign xfer      = out_valid && out_ready;
    assign drop      = busy && (in_valid || in_finish);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en     = 1'b0;
        clear_all = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                wr_en = in_valid;
                if (in_finish) begin
                    state_d = DRAIN;
                    idx_d   = first_idx;
                end else if (in_valid) begin
                    state_d = COLLECT;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d   = IDLE;
                        clear_all = 1'b1;
                        idx_d     = '0;
                    end else begin
                        idx_d = next_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spmv_result_packer.sv
// Self-checking bench for spmv_result_packer: table vectors, corner sequences, random vectors.
module tb_spmv_result_packer;

    localparam int NR = 32;
    localparam int DW = 21;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [4:0]    in_row = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_finish = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [4:0]    out_idx;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    spmv_result_packer #(
        .NUM_ROWS (NR),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_data   (in_data),
        .in_finish (in_finish),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        int row;
        int data;
        int exp;
    } vec_t;

    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;

    int errors = 0;
    int checks = 0;
    int model [NR];
    bit mwr [NR];
    int got [NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            model[i] = 0;
            mwr[i]   = 0;
        end
    endtask

    task automatic beat(input bit v, input int row, input int data, input bit fin);
        @(negedge clk);
        in_valid  = v;
        in_row    = row[4:0];
        in_data   = data[DW-1:0];
        in_finish = fin;
        if (v) begin
            model[row] = (model[row] + data) % (1 << DW);
            mwr[row]   = 1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_finish = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"},  32'(out_last),  0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_overrun"},   32'(overrun),   0);
        chk({tag, "_out_idx"},   32'(out_idx),   0);
        chk({tag, "_out_data"},  32'(out_data),  0);
    endtask

    // Expected stream comes straight from the row model; ready may stall at one index or at random.
    task automatic drain(input int stall_at, input bit rnd);
        beat_t         exp[$];
        int            k = 0;
        int            cyc = 0;
        int            stall_left = 5;
        bit            hold = 0;
        logic [4:0]    p_idx = '0;
        logic [DW-1:0] p_data = '0;
        logic          p_last = 1'b0;
`ifdef SPMV_PACK_SKIP_ZERO_EN
        for (int i = 0; i < NR; i++) begin
            if (mwr[i]) exp.push_back('{i, model[i], 1'b0});
        end
        if (exp.size() == 0) exp.push_back('{0, 0, 1'b1});
        else exp[exp.size() - 1].last = 1'b1;
`else
        for (int i = 0; i < NR; i++) exp.push_back('{i, model[i], i == NR - 1});
`endif
        for (int i = 0; i < NR; i++) got[i] = -1;
        while (k < exp.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_idx", 32'(out_idx), 32'(p_idx));
                chk("hold_data", 32'(out_data), 32'(p_data));
                chk("hold_last", 32'(out_last), 32'(p_last));
            end
            if (stall_at >= 0 && out_valid && int'(out_idx) == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("beat_idx", 32'(out_idx), 32'(exp[k].idx));
                chk("beat_data", 32'(out_data), 32'(exp[k].data));
                chk("beat_last", 32'(out_last), 32'(exp[k].last));
                got[out_idx] = int'(out_data);
                k++;
            end
            hold   = out_valid && !out_ready;
            p_idx  = out_idx;
            p_data = out_data;
            p_last = out_last;
        end
        chk("beat_count", 32'(k), 32'(exp.size()));
        if (stall_at < 0 && !rnd) chk("drain_cycles", 32'(cyc), 32'(exp.size()));
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_drain_valid", 32'(out_valid), 0);
        chk("idle_after_drain_busy", 32'(busy), 0);
        model_clear();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        bit   reached;
        tbl[0] = '{4,  'h1FFFFF, 1};
        tbl[1] = '{4,  2,        1};
        tbl[2] = '{9,  1000,     1500};
        tbl[3] = '{9,  500,      1500};
        tbl[4] = '{31, 'h10,     'h10};
        tbl[5] = '{0,  1,        0};
        tbl[6] = '{0,  'h1FFFFF, 0};

        model_clear();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two sparse rows, full-speed drain.
        beat(1, 3, 100, 0);
        beat(1, 17, 5, 0);
        beat(0, 0, 0, 1);
        drain(-1, 0);
        chk("t1_row3", 32'(got[3]), 100);
        chk("t1_row17", 32'(got[17]), 5);

        // Table of accumulating beats including modular wrap.
        for (int i = 0; i < 7; i++) beat(1, tbl[i].row, tbl[i].data, 0);
        beat(0, 0, 0, 1);
        drain(-1, 0);
        for (int i = 0; i < 7; i++) chk("tbl_row_value", 32'(got[tbl[i].row]), 32'(tbl[i].exp));

        // Backpressure held five cycles at idx 7.
        beat(1, 7, 77, 0);
        beat(1, 8, 88, 0);
        beat(0, 0, 0, 1);
        drain(7, 0);

        // Beat with finish is stored; beat during drain is dropped and flags overrun.
        beat(1, 31, 9, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_row   = 5'd5;
        in_data  = 21'd55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t4_busy_during_drain", 32'(busy), 1);
        drain(-1, 0);
        chk("t4_row31", 32'(got[31]), 9);
        chk("t4_overrun", 32'(overrun), 1);
        beat(0, 0, 0, 1);
        drain(-1, 0);
        chk("t4_overrun_sticky", 32'(overrun), 1);

        // Reset at idx 10 aborts the drain; next vector starts clean.
        beat(1, 0, 11, 0);
        beat(1, 5, 22, 0);
        beat(1, 10, 33, 0);
        beat(1, 12, 44, 0);
        beat(0, 0, 0, 1);
        reached = 0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'd10) reached = 1;
            out_ready = 1'b1;
        end
        chk("t5_reached_idx10", 32'(reached), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("t5_reset");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_no_beat_after_reset", 32'(out_valid), 0);
        end
        out_ready = 1'b0;
        model_clear();
        beat(1, 1, 3, 0);
        beat(0, 0, 0, 1);
        drain(-1, 0);

`ifdef SPMV_PACK_SKIP_ZERO_EN
        beat(1, 2, 20, 0);
        beat(1, 30, 300, 0);
        beat(0, 0, 0, 1);
        drain(-1, 0);
        chk("t6_row30", 32'(got[30]), 300);
`endif

        // Random vectors with random backpressure.
        for (int v = 0; v < 12; v++) begin
            int n;
            bit fin_done;
            n = $urandom_range(0, 6);
            fin_done = 0;
            for (int j = 0; j < n; j++) begin
                bit fin;
                if ($urandom_range(0, 3) == 0) beat(0, 0, 0, 0);
                fin = (j == n - 1) && ($urandom_range(0, 1) == 1);
                beat(1, $urandom_range(0, NR - 1), $urandom_range(0, (1 << DW) - 1), fin);
                fin_done = fin;
            end
            if (!fin_done) beat(0, 0, 0, 1);
            drain(-1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
